hard_sector_index_generator: RTL and testbench

Generates the index-hole pulse train of a hard-sectored disc: one hole per sector plus the extra track-mark hole midway between the last sector hole and sector 0. It acts as the drive-side source for the hard-sector index path. Uses include drive emulation, loopback self-test of the track-mark detection logic, and bench stimulus. All timing is counted in clock-enable ticks.

---
 rtl/hard_sector_index_generator.sv | 101 ++++++++++
 tb/tb_hard_sector_index_generator.sv | 135 +++++++++++++
 2 files changed

// File: rtl/hard_sector_index_generator.sv
// hard_sector_index_generator: hard-sectored disc index-hole pulse train with track-mark hole.
// Geometry is latched at start and at each wrap, so a revolution always finishes with one config.
module hard_sector_index_generator (
    input  logic        clock,
    input  logic        reset,
    input  logic        cke,
    input  logic        enable,
    input  logic [7:0]  sector_count,
    input  logic [15:0] period,
    input  logic [7:0]  pulse_width,
    output logic        index,
    output logic        track_mark,
    output logic [7:0]  sector,
    output logic        rev_strobe,
    output logic        running,
    output logic        cfg_error
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state_q, state_d;
    logic [15:0] t_q, t_d, p_q, p_d, h_q, h_d;
    logic [7:0] sector_q, sector_d, s_q, s_d, w_q, w_d;
    logic index_q, index_d, track_mark_q, track_mark_d, rev_strobe_q, rev_strobe_d;
    logic cfg_error_q, cfg_error_d, cfg_ok, start;
    always_comb begin
        cfg_ok = (sector_count >= 8'd2) && (pulse_width != 8'd0) &&
                 ({8'd0, pulse_width} < (period >> 1));
        start = 1'b0;
        state_d = state_q;
        t_d = t_q;
        sector_d = sector_q;
        cfg_error_d = cfg_error_q;
        rev_strobe_d = 1'b0;
        if (cke) begin
            if (state_q == IDLE) begin
                if (enable && cfg_ok) start = 1'b1;
                else if (enable) cfg_error_d = 1'b1;
            end else if (t_q < p_q - 16'd1) begin
                t_d = t_q + 16'd1;
            end else if (sector_q < s_q - 8'd1) begin
                t_d = 16'd0;
                sector_d = sector_q + 8'd1;
            end else begin
                t_d = 16'd0;
                sector_d = 8'd0;
                if (enable && cfg_ok) start = 1'b1;
                else begin
                    state_d = IDLE;
                    if (enable) cfg_error_d = 1'b1;
                end
            end
        end
        if (start) begin
            state_d = RUN;
            t_d = 16'd0;
            sector_d = 8'd0;
            rev_strobe_d = 1'b1;
            cfg_error_d = 1'b0;
        end
        s_d = start ? sector_count : s_q;
        p_d = start ? period : p_q;
        w_d = start ? pulse_width : w_q;
        h_d = start ? (period >> 1) : h_q;
        // Outputs decode the post-edge state so they stay registered yet aligned with it
        track_mark_d = (state_d == RUN) && (sector_d == s_d - 8'd1) && (t_d >= h_d) &&
                       ({1'b0, t_d} < {1'b0, h_d} + {9'd0, w_d});
        index_d = (state_d == RUN) && ((t_d < {8'd0, w_d}) || track_mark_d);
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            t_q <= '0;
            sector_q <= '0;
            s_q <= '0;
            p_q <= '0;
            w_q <= '0;
            h_q <= '0;
            index_q <= 1'b0;
            track_mark_q <= 1'b0;
            rev_strobe_q <= 1'b0;
            cfg_error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q <= t_d;
            sector_q <= sector_d;
            s_q <= s_d;
            p_q <= p_d;
            w_q <= w_d;
            h_q <= h_d;
            index_q <= index_d;
            track_mark_q <= track_mark_d;
            rev_strobe_q <= rev_strobe_d;
            cfg_error_q <= cfg_error_d;
        end
    end
    assign index = index_q;
    assign track_mark = track_mark_q;
    assign sector = sector_q;
    assign rev_strobe = rev_strobe_q;
    assign running = (state_q == RUN);
    assign cfg_error = cfg_error_q;
endmodule

// File: tb/tb_hard_sector_index_generator.sv
// tb_hard_sector_index_generator: directed checks of hole timing, cke gating, stop, config errors and reset.
module tb_hard_sector_index_generator;
    logic clock = 1'b0, reset = 1'b1, cke = 1'b0, enable = 1'b0;
    logic [7:0] sector_count = 8'd4, pulse_width = 8'd2;
    logic [15:0] period = 16'd20;
    logic index, track_mark, rev_strobe, running, cfg_error;
    logic [7:0] sector;
    int errors = 0, checks = 0;

    hard_sector_index_generator dut (
        .clock(clock), .reset(reset), .cke(cke), .enable(enable),
        .sector_count(sector_count), .period(period), .pulse_width(pulse_width),
        .index(index), .track_mark(track_mark), .sector(sector),
        .rev_strobe(rev_strobe), .running(running), .cfg_error(cfg_error)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at %0t: observed=%0d expected=%0d", tag, $time, obs, exp);
        end
    endtask

    // Expected outputs at revolution tick r for S=4, W=2: holes at k*P, track mark at 3P+P/2
    task automatic chk_rev(input int t, input int p, input bit rev_exp);
        int r, h;
        bit tm;
        r = t % (4 * p);
        h = p / 2;
        tm = (r >= 3 * p + h) && (r < 3 * p + h + 2);
        chk("index", 16'(index), 16'((r % p < 2) || tm));
        chk("track_mark", 16'(track_mark), 16'(tm));
        chk("sector", 16'(sector), 16'(r / p));
        chk("rev_strobe", 16'(rev_strobe), 16'(rev_exp));
        chk("running", 16'(running), 16'd1);
        chk("cfg_error", 16'(cfg_error), 16'd0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_index"}, 16'(index), 16'd0);
        chk({tag, "_track_mark"}, 16'(track_mark), 16'd0);
        chk({tag, "_rev_strobe"}, 16'(rev_strobe), 16'd0);
        chk({tag, "_running"}, 16'(running), 16'd0);
        chk({tag, "_sector"}, 16'(sector), 16'd0);
    endtask

    // Reset is released just after an edge, so the following edge is cycle 0
    task automatic start(input logic [15:0] p, input logic [7:0] w, input logic en);
        reset = 1'b1;
        cke = 1'b1;
        enable = en;
        period = p;
        pulse_width = w;
        sector_count = 8'd4;
        step();
        chk_idle("reset");
        chk("reset_cfg_error", 16'(cfg_error), 16'd0);
        reset = 1'b0;
    endtask

    initial begin
        // Basic revolution
        start(16'd20, 8'd2, 1'b1);
        for (int c = 0; c <= 80; c++) begin
            step();
            chk_rev(c, 20, c == 0 || c == 80);
        end
        // cke toggling 1-0: events take twice as many clocks, rev_strobe stays one clock
        start(16'd20, 8'd2, 1'b1);
        for (int k = 0; k <= 161; k++) begin
            step();
            chk_rev(k / 2, 20, k == 0 || k == 160);
            cke = ((k + 1) % 2 == 0);
        end
        cke = 1'b1;
        // enable dropped mid-revolution: revolution completes, then idle
        start(16'd20, 8'd2, 1'b1);
        for (int c = 0; c <= 79; c++) begin
            step();
            chk_rev(c, 20, c == 0);
            if (c == 30) enable = 1'b0;
        end
        for (int c = 80; c <= 83; c++) begin
            step();
            chk_idle("stopped");
        end
        enable = 1'b1;
        step();
        chk("restart_running", 16'(running), 16'd1);
        chk("restart_rev", 16'(rev_strobe), 16'd1);
        // Invalid config W>=H, then fixed
        start(16'd20, 8'd10, 1'b1);
        for (int c = 0; c <= 2; c++) begin
            step();
            chk_idle("badcfg");
            chk("badcfg_cfg_error", 16'(cfg_error), 16'd1);
        end
        pulse_width = 8'd3;
        step();
        chk("fixed_running", 16'(running), 16'd1);
        chk("fixed_index", 16'(index), 16'd1);
        chk("fixed_rev", 16'(rev_strobe), 16'd1);
        chk("fixed_cfg_error", 16'(cfg_error), 16'd0);
        // Period change mid-revolution takes effect at the wrap
        start(16'd20, 8'd2, 1'b1);
        for (int c = 0; c <= 240; c++) begin
            step();
            if (c < 80) chk_rev(c, 20, c == 0);
            else chk_rev(c - 80, 40, c == 80 || c == 240);
            if (c == 25) period = 16'd40;
        end
        // Async reset during the track-mark pulse
        start(16'd20, 8'd2, 1'b1);
        for (int c = 0; c <= 71; c++) begin
            step();
            chk_rev(c, 20, c == 0);
        end
        #1 reset = 1'b1;
        #1;
        chk_idle("async_reset");
        #3 reset = 1'b0;
        step();
        chk_rev(0, 20, 1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
